// File: rtl/pong_solve_sequencer.sv
// Frame sequencer: per tick, solves left then right paddle, then ball update, then draw (timeout via PONG_SEQ_TIMEOUT_EN).
// Latency: startSolve/isActiveL 1 cycle after an accepted tick; startBall 9+ cycles after it.
// Backpressure: each step waits for its solved/done response; ticks arriving while busy are dropped and counted.
module pong_solve_sequencer #(
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int OVR_W          = 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             frameTick,
    input  logic [1:0]       keysL,
    input  logic [1:0]       keysR,
    input  logic             isSolvedL,
    input  logic             isSolvedR,
    input  logic             ballDone,
    input  logic             drawDone,
    output logic             startSolve,
    output logic             isActiveL,
    output logic             isActiveR,
    output logic [1:0]       userInputL,
    output logic [1:0]       userInputR,
    output logic             startBall,
    output logic             startDraw,
    output logic             busy,
    output logic [OVR_W-1:0] overrunCount,
    output logic             timeoutErr
);

    typedef enum logic [3:0] {
        IDLE,
        SOLVE_L,
        GAP_L,
        SOLVE_R,
        GAP_R,
        BALL_START,
        BALL_WAIT,
        DRAW_START,
        DRAW_WAIT
    } state_t;

    state_t state;
    logic   leave;
    logic   expired;

    // Both keys pressed cancels out, so 2'b11 can never reach a paddle.
    function automatic logic [1:0] encode_keys(input logic [1:0] keys);
        return {keys[1] & ~keys[0], keys[0] & ~keys[1]};
    endfunction

    // Exit condition of the current state; a timeout forces it in wait states.
    always_comb begin
        leave = 1'b0;
        case (state)
            IDLE:       leave = frameTick;
            SOLVE_L:    leave = isSolvedL | expired;
            GAP_L:      leave = ~isSolvedL | expired;
            SOLVE_R:    leave = isSolvedR | expired;
            GAP_R:      leave = ~isSolvedR | expired;
            BALL_START: leave = 1'b1;
            BALL_WAIT:  leave = ballDone | expired;
            DRAW_START: leave = 1'b1;
            DRAW_WAIT:  leave = drawDone | expired;
            default:    leave = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            startSolve   <= 1'b0;
            isActiveL    <= 1'b0;
            isActiveR    <= 1'b0;
            userInputL   <= 2'b00;
            userInputR   <= 2'b00;
            startBall    <= 1'b0;
            startDraw    <= 1'b0;
            busy         <= 1'b0;
            overrunCount <= '0;
        end else begin
            startBall <= 1'b0;
            startDraw <= 1'b0;

            // A tick landing on the DRAW_WAIT->IDLE cycle is still a miss.
            if (frameTick && (state != IDLE) && (overrunCount != {OVR_W{1'b1}}))
                overrunCount <= overrunCount + 1'b1;

            if (leave) begin
                case (state)
                    IDLE: begin
                        state      <= SOLVE_L;
                        userInputL <= encode_keys(keysL);
                        userInputR <= encode_keys(keysR);
                        startSolve <= 1'b1;
                        isActiveL  <= 1'b1;
                        busy       <= 1'b1;
                    end
                    SOLVE_L: begin
                        state      <= GAP_L;
                        startSolve <= 1'b0;
                        isActiveL  <= 1'b0;
                    end
                    GAP_L: begin
                        state      <= SOLVE_R;
                        startSolve <= 1'b1;
                        isActiveR  <= 1'b1;
                    end
                    SOLVE_R: begin
                        state      <= GAP_R;
                        startSolve <= 1'b0;
                        isActiveR  <= 1'b0;
                    end
                    GAP_R: begin
                        state     <= BALL_START;
                        startBall <= 1'b1;
                    end
                    BALL_START: state <= BALL_WAIT;
                    BALL_WAIT: begin
                        state     <= DRAW_START;
                        startDraw <= 1'b1;
                    end
                    DRAW_START: state <= DRAW_WAIT;
                    DRAW_WAIT: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef PONG_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] wait_cnt;
    logic          in_wait;

    assign in_wait = (state == SOLVE_L) || (state == GAP_L) || (state == SOLVE_R) ||
                     (state == GAP_R) || (state == BALL_WAIT) || (state == DRAW_WAIT);
    assign expired = in_wait && (wait_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Counter restarts on every state exit, so each wait starts from zero.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wait_cnt   <= '0;
            timeoutErr <= 1'b0;
        end else begin
            if (leave)
                wait_cnt <= '0;
            else if (in_wait)
                wait_cnt <= wait_cnt + 1'b1;
            if (expired)
                timeoutErr <= 1'b1;
        end
    end
`else
    // No wait bound: the FSM waits indefinitely and timeoutErr is constant 0.
    assign expired    = 1'b0;
    assign timeoutErr = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_pong_solve_sequencer.sv
// Bench for pong_solve_sequencer: reactive responders plus a frame-timing reference model.
module tb_pong_solve_sequencer;

    logic       clock = 1'b0;
    logic       resetn;
    logic       frameTick;
    logic [1:0] keysL, keysR;
    logic       isSolvedL, isSolvedR, ballDone, drawDone;
    logic       startSolve, isActiveL, isActiveR, startBall, startDraw, busy, timeoutErr;
    logic [1:0] userInputL, userInputR;
    logic [7:0] overrunCount;
    logic       s2_startSolve, s2_isActiveL, s2_isActiveR, s2_startBall, s2_startDraw, s2_busy, s2_timeoutErr;
    logic [1:0] s2_userInputL, s2_userInputR;
    logic [1:0] s2_overrunCount;

    pong_solve_sequencer #(.TIMEOUT_CYCLES(16), .OVR_W(8)) dut (
        .clock(clock), .resetn(resetn), .frameTick(frameTick), .keysL(keysL), .keysR(keysR),
        .isSolvedL(isSolvedL), .isSolvedR(isSolvedR), .ballDone(ballDone), .drawDone(drawDone),
        .startSolve(startSolve), .isActiveL(isActiveL), .isActiveR(isActiveR),
        .userInputL(userInputL), .userInputR(userInputR), .startBall(startBall),
        .startDraw(startDraw), .busy(busy), .overrunCount(overrunCount), .timeoutErr(timeoutErr)
    );

    pong_solve_sequencer #(.TIMEOUT_CYCLES(16), .OVR_W(2)) dut_sat (
        .clock(clock), .resetn(resetn), .frameTick(frameTick), .keysL(keysL), .keysR(keysR),
        .isSolvedL(isSolvedL), .isSolvedR(isSolvedR), .ballDone(ballDone), .drawDone(drawDone),
        .startSolve(s2_startSolve), .isActiveL(s2_isActiveL), .isActiveR(s2_isActiveR),
        .userInputL(s2_userInputL), .userInputR(s2_userInputR), .startBall(s2_startBall),
        .startDraw(s2_startDraw), .busy(s2_busy), .overrunCount(s2_overrunCount),
        .timeoutErr(s2_timeoutErr)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    int hold_cfg = 0, sr_cfg = 0, db_cfg = 0, dd_cfg = 0;
    int hold_cnt = 0, req_r_cnt = 0, ball_cnt = -1, draw_cnt = -1;

    logic [7:0] exp_ovr  = 8'd0;
    logic [1:0] exp_ovr2 = 2'd0;
    logic [1:0] exp_ul   = 2'b00;
    logic [1:0] exp_ur   = 2'b00;
    logic       exp_terr = 1'b0;
    bit         pend     = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] enc(input logic [1:0] k);
        case (k)
            2'b10:   return 2'b10;
            2'b01:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    // Advance one cycle; responders are registered, reacting to what they saw last cycle.
    task automatic tick_clk();
        logic ssp, alp, arp;
        ssp = startSolve; alp = isActiveL; arp = isActiveR;
        @(posedge clock); #1;
        if (ssp && alp) begin
            isSolvedL = 1'b1; hold_cnt = hold_cfg;
        end else if (isSolvedL && hold_cnt > 0) hold_cnt--;
        else isSolvedL = 1'b0;
        if (ssp && arp) req_r_cnt++; else req_r_cnt = 0;
        isSolvedR = (req_r_cnt > sr_cfg);
        ballDone = 1'b0;
        if (ball_cnt == 0) begin ballDone = 1'b1; ball_cnt = -1; end
        else if (ball_cnt > 0) ball_cnt--;
        if (startBall) ball_cnt = db_cfg;
        drawDone = 1'b0;
        if (draw_cnt == 0) begin drawDone = 1'b1; draw_cnt = -1; end
        else if (draw_cnt > 0) draw_cnt--;
        if (startDraw) draw_cnt = dd_cfg;
    endtask

    task automatic apply_pend();
        if (pend) begin
            if (exp_ovr != 8'hFF) exp_ovr++;
            if (exp_ovr2 != 2'b11) exp_ovr2++;
            pend = 1'b0;
        end
    endtask

    task automatic check_all(input logic e_ss, e_al, e_ar, e_sb, e_sd, e_busy);
        chk("startSolve", 32'(startSolve), 32'(e_ss));
        chk("isActiveL", 32'(isActiveL), 32'(e_al));
        chk("isActiveR", 32'(isActiveR), 32'(e_ar));
        chk("startBall", 32'(startBall), 32'(e_sb));
        chk("startDraw", 32'(startDraw), 32'(e_sd));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("userInputL", 32'(userInputL), 32'(exp_ul));
        chk("userInputR", 32'(userInputR), 32'(exp_ur));
        chk("overrunCount", 32'(overrunCount), 32'(exp_ovr));
        chk("overrunCount_w2", 32'(s2_overrunCount), 32'(exp_ovr2));
        chk("timeoutErr", 32'(timeoutErr), 32'(exp_terr));
    endtask

    task automatic chk_zero();
        check_all(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            tick_clk();
            apply_pend();
            check_all(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            frameTick = 1'b0;
            keysL = 2'($urandom); keysR = 2'($urandom);
            if ($urandom_range(3, 0) == 0) ballDone = 1'b1;
            if ($urandom_range(3, 0) == 0) drawDone = 1'b1;
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        frameTick = 1'b0;
        exp_ovr = 8'd0; exp_ovr2 = 2'd0; exp_ul = 2'b00; exp_ur = 2'b00; exp_terr = 1'b0; pend = 1'b0;
        #1;
        chk_zero();
        isSolvedL = 1'b0; isSolvedR = 1'b0; ballDone = 1'b0; drawDone = 1'b0;
        hold_cnt = 0; req_r_cnt = 0; ball_cnt = -1; draw_cnt = -1;
        @(posedge clock); @(posedge clock); #1;
        chk_zero();
        resetn = 1'b1;
    endtask

    // One frame from an IDLE cycle. Model (k = cycles after tick, a = h+sr):
    // isActiveL k=1..2, isActiveR k=5+h..6+a, startBall 9+a, startDraw 11+a+db, busy 1..12+a+db+dd.
    task automatic run_frame(input int h, sr, db, dd, ovr_pct, n_ball_ticks, rst_at,
                             input bit noise, fixed_keys, input logic [1:0] kl, kr);
        int a, len;
        logic [1:0] nl, nr;
        hold_cfg = h; sr_cfg = sr; db_cfg = db; dd_cfg = dd;
        a = h + sr;
        len = 12 + a + db + dd;
        if (fixed_keys) begin keysL = kl; keysR = kr; end
        else begin keysL = 2'($urandom); keysR = 2'($urandom); end
        nl = enc(keysL); nr = enc(keysR);
        frameTick = 1'b1;
        for (int k = 1; k <= len + 1; k++) begin
            tick_clk();
            apply_pend();
            if (k == 1) begin exp_ul = nl; exp_ur = nr; end
            check_all((k <= 2) || (k >= 5 + h && k <= 6 + a), k <= 2, k >= 5 + h && k <= 6 + a,
                      k == 9 + a, k == 11 + a + db, k <= len);
            if (k == rst_at) begin
                do_reset();
                return;
            end
            frameTick = 1'b0;
            if (k <= len) begin
                if (n_ball_ticks > 0 && k >= 10 + a && k < 10 + a + n_ball_ticks) frameTick = 1'b1;
                else if (int'($urandom_range(99, 0)) < ovr_pct) frameTick = 1'b1;
                if (frameTick) pend = 1'b1;
            end
            keysL = 2'($urandom); keysR = 2'($urandom);
            if (noise) begin
                if (k <= 9 + a && $urandom_range(3, 0) == 0) ballDone = 1'b1;
                if (k <= 11 + a + db && $urandom_range(3, 0) == 0) drawDone = 1'b1;
            end
        end
    endtask

    initial begin
        resetn = 1'b0; frameTick = 1'b0; keysL = 2'b00; keysR = 2'b00;
        isSolvedL = 1'b0; isSolvedR = 1'b0; ballDone = 1'b0; drawDone = 1'b0;
        #3;
        chk_zero();
        @(posedge clock); @(posedge clock); #1;
        resetn = 1'b1;
        idle(2);

        run_frame(0, 0, 0, 0, 0, 0, -1, 1'b0, 1'b1, 2'b10, 2'b11);
        chk("enc_up_only", 32'(userInputL), 32'h2);
        chk("enc_both", 32'(userInputR), 32'h0);
        run_frame(0, 0, 5, 5, 0, 0, -1, 1'b0, 1'b1, 2'b01, 2'b00);
        chk("enc_down_only", 32'(userInputL), 32'h1);
        run_frame(4, 0, 0, 0, 0, 0, -1, 1'b0, 1'b0, 2'b00, 2'b00);
        idle(1);

        run_frame(0, 0, 5, 0, 0, 3, -1, 1'b0, 1'b0, 2'b00, 2'b00);
        chk("ovr_three", 32'(overrunCount), 32'd3);
        run_frame(0, 0, 5, 0, 0, 2, -1, 1'b0, 1'b0, 2'b00, 2'b00);
        chk("ovr_five", 32'(overrunCount), 32'd5);
        chk("ovr_sat_w2", 32'(s2_overrunCount), 32'd3);

        run_frame(0, 0, 0, 0, 0, 0, 5, 1'b0, 1'b0, 2'b00, 2'b00);
        idle(2);
        run_frame(1, 1, 2, 2, 0, 0, -1, 1'b1, 1'b1, 2'b01, 2'b10);

        repeat (25) begin
            run_frame(int'($urandom_range(4, 0)), int'($urandom_range(3, 0)),
                      int'($urandom_range(6, 0)), int'($urandom_range(6, 0)),
                      20, 0, -1, 1'b1, 1'b0, 2'b00, 2'b00);
            idle(int'($urandom_range(2, 0)));
        end

`ifdef PONG_SEQ_TIMEOUT_EN
        begin
            int  nact = 0, nball = 0;
            bit  fin  = 1'b0;
            hold_cfg = 0; sr_cfg = 100000; db_cfg = 0; dd_cfg = 0;
            frameTick = 1'b1;
            for (int c = 0; c < 200 && !fin; c++) begin
                tick_clk();
                frameTick = 1'b0;
                if (isActiveR) nact++;
                if (startBall) nball++;
                if (c > 2 && !busy) fin = 1'b1;
            end
            chk("timeout_active_cycles", 32'(nact), 32'd16);
            chk("timeout_err", 32'(timeoutErr), 32'd1);
            chk("timeout_ball_pulses", 32'(nball), 32'd1);
            chk("timeout_completes", 32'(fin), 32'd1);
            idle(0);
            tick_clk();
            chk("timeout_sticky", 32'(timeoutErr), 32'd1);
        end
`else
        run_frame(0, 40, 0, 0, 0, 0, -1, 1'b0, 1'b0, 2'b00, 2'b00);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pong_solve_sequencer.md
Name: pong_solve_sequencer

Overview:
- Initiator side of the paddle solve handshake (startSolve / isActive / isSolved / UserInput).
- Once per frame tick it samples both players' keys and encodes them into 2-bit UserInput codes.
- It then runs each paddle's solve handshake in turn (left, then right), starts the ball update, then starts the draw.
- Sits between the frame counter/key inputs and the paddle, ball and draw blocks.

Parameters:
- TIMEOUT_CYCLES, 1023: maximum cycles spent waiting on any single done/solved response; used only with the optional feature.
- OVR_W, 8: width of the saturating frame-overrun counter.

Ports:
- clock  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- frameTick  in  1  one-cycle pulse at the start of each frame
- keysL  in  2  left player keys, [1]=up, [0]=down, active-high
- keysR  in  2  right player keys, same encoding
- isSolvedL  in  1  left paddle solved flag
- isSolvedR  in  1  right paddle solved flag
- ballDone  in  1  ball update finished (pulse or level)
- drawDone  in  1  draw finished (pulse or level)
- startSolve  out  1  solve request, shared by both paddles
- isActiveL  out  1  selects left paddle
- isActiveR  out  1  selects right paddle
- userInputL  out  2  encoded left command
- userInputR  out  2  encoded right command
- startBall  out  1  one-cycle ball update start
- startDraw  out  1  one-cycle draw start
- busy  out  1  high whenever state is not IDLE
- overrunCount  out  OVR_W  count of frame ticks missed while busy
- timeoutErr  out  1  sticky timeout flag

Behaviour:
- Reset: clock and reset are one clock plus asynchronous active-low resetn. While resetn=0, every output is 0 and state=IDLE.
- All outputs are registered.
- Key encoding, latched only on an accepted tick:
  - up only -> 2'b10
  - down only -> 2'b01
  - none or both -> 2'b00
  - 2'b11 is never driven, because the responder would never assert solved on it.
- userInputL/R hold their value until the next accepted tick.
- States: IDLE, SOLVE_L, GAP_L, SOLVE_R, GAP_R, BALL_START, BALL_WAIT, DRAW_START, DRAW_WAIT.
- IDLE:
  - frameTick=1 -> latch codes, go to SOLVE_L.
  - startSolve=0, isActiveL=0, isActiveR=0.
- SOLVE_L:
  - startSolve=1, isActiveL=1.
  - Holds until isSolvedL=1, then goes to GAP_L.
- GAP_L:
  - startSolve=0, isActiveL=0.
  - Waits until isSolvedL=0, then goes to SOLVE_R.
  - Guarantees the responder has cleared before the next frame.
- SOLVE_R / GAP_R: identical to SOLVE_L / GAP_L, using isActiveR and isSolvedR; GAP_R exits to BALL_START.
- BALL_START: startBall=1 for exactly one cycle, then BALL_WAIT.
- BALL_WAIT: on ballDone=1 go to DRAW_START.
- DRAW_START: startDraw=1 for exactly one cycle, then DRAW_WAIT.
- DRAW_WAIT: on drawDone=1 go to IDLE.
- isActiveL and isActiveR are never high in the same cycle.
- Nominal latency (responders answering in 1 cycle):
  - tick at cycle t -> startSolve/isActiveL high at t+1.
  - startBall pulse at t+9 or later.
- Overrun:
  - frameTick=1 while state != IDLE -> tick ignored, overrunCount+1, saturating at all-ones.
  - A tick in the same cycle as the DRAW_WAIT->IDLE transition counts as an overrun.
- Done inputs are ignored outside their wait state; a stale ballDone/drawDone level has no effect.
- Reset mid-sequence returns to IDLE immediately with all outputs cleared, including overrunCount and timeoutErr.

Optional Feature:
- Macro: PONG_SEQ_TIMEOUT_EN.
- Defined:
  - A wait counter is cleared on entry to each SOLVE_*, GAP_* and *_WAIT state.
  - When it reaches TIMEOUT_CYCLES in a state, timeoutErr is set (sticky until reset) and the FSM forces the exit transition as if the awaited condition had occurred.
- Undefined:
  - No counter is built; timeoutErr is tied to 0.
  - The FSM waits indefinitely.

Test Plan:
- Reset at arbitrary state (hold resetn=0 during SOLVE_R) -> all outputs 0; after release, next frameTick starts SOLVE_L.
- keysL=2'b10, keysR=2'b11, tick; model responders reply in 1 cycle -> userInputL=2'b10, userInputR=2'b00; isActiveL then isActiveR, never overlapping; one startBall pulse, then one startDraw pulse.
- Full frame with ballDone and drawDone each delayed 5 cycles -> busy stays high throughout; returns to IDLE the cycle after drawDone.
- Three ticks during BALL_WAIT -> overrunCount=3, FSM unaffected; with OVR_W=2, 5 overrun ticks -> overrunCount=3.
- Left responder holds isSolvedL=1 after isActiveL drops for 4 cycles -> FSM stays in GAP_L 4 cycles; isActiveR asserts only after isSolvedL=0.
- With PONG_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=16, isSolvedR stuck at 0 -> after 16 cycles timeoutErr=1, startBall pulses, sequence completes; without the macro -> FSM stays in SOLVE_R and timeoutErr=0.
